cla_nibble_sequencer: RTL and testbench
=======================================

# cla_nibble_sequencer

Multi-cycle wide adder that time-multiplexes one 4-bit carry-lookahead slice across a WIDTH-bit operand pair, one nibble per clock, least-significant nibble first. It sits directly upstream of the 4-bit `adder` slice (sum, cout, in1, in2, cin). It presents one nibble pair and the registered carry to the slice each cycle, and it consumes the slice's sum and cout. The result is a full-width sum with carry-out and a signed-overflow flag. It lets the datapath perform 8/16/32-bit additions without replicating the adder.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 8; N = WIDTH/4 nibble steps per operation
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in to nibble 0; captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow = carry into bit WIDTH-1 XOR cout

## Operation
- One internal instance of the 4-bit `adder` slice:
  - in1 = A_reg[4k+3:4k]
  - in2 = B_reg[4k+3:4k]
  - cin = carry_reg
- FSM states IDLE, RUN, DONE; reset state IDLE.
- IDLE, start=1:
  - Latch a, b, cin into A_reg, B_reg, carry_reg.
  - Set k=0, clear the partial-sum register, go to RUN.
- IDLE, start=0: stay.
- RUN, each edge:
  - Write the slice sum into partial[4k+3:4k].
  - Load the slice cout into carry_reg.
  - For k = N-1, also capture the carry into bit WIDTH-1 (from the slice's internal bit-3 carry, or recomputed as a[3]^b[3]^sum[3] of the top nibble).
  - If k = N-1, go to DONE. Otherwise k = k+1.
- RUN to DONE edge: load partial into sum, load carry_reg into cout, load the overflow result into ovf.
- DONE: done=1 for exactly that cycle.
  - start=1 is accepted exactly as in IDLE (back-to-back operation); otherwise return to IDLE.
- start while busy=1 (RUN) is ignored. No queuing, no error flag.
- sum, cout and ovf hold the last completed result until the next completion. They do not change during RUN.
- a, b and cin may change freely after the accepting edge.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, k=0, carry_reg=0, state IDLE.
- Reset asserted mid-RUN aborts the operation. All outputs return to reset values on that edge, and no done pulse is produced.
- Reset dominates start on the same edge.

## Timing
- busy is registered:
  - 1 from the edge after the accepting edge through the last RUN edge.
  - 0 in the DONE cycle.
- Latency: start sampled at edge E0; nibble k is written at edge E(k+1).
- done and the valid result are visible after edge EN. For WIDTH=16, done is high in the cycle after E4.
- Throughput: one operation per N+1 cycles with start held or re-pulsed in DONE. One operation per N+2 cycles if start arrives in IDLE.
- Slice path: combinational from A_reg/B_reg/k/carry_reg to the partial and carry registers. One 4-bit CLA delay plus a WIDTH/4-way nibble mux per cycle.
- No output is combinationally dependent on any input.

## Test plan
- Reset: hold rst 2 cycles with start=1, a=0xFFFF, b=0xFFFF.
  - Required: busy=0, done=0, sum=0x0000, cout=0, ovf=0 throughout, and no operation after rst drops until start is sampled.
- Carry ripple (WIDTH=16): a=0xFFFF, b=0x0001, cin=0.
  - Required: done after exactly 4 edges; sum=0x0000, cout=1, ovf=0.
  - Also run a=0x0000, b=0xFFFF, cin=1 → sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
  - Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Mixed nibbles: a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
  - Also a=0x0F0F, b=0x00F1, cin=0 → 0x1000.
  - sum must keep its previous value during all RUN cycles.
- Busy protection and abort:
  - Pulse start with a=0x1111 during RUN → ignored; the first result completes unchanged.
  - Assert rst at the second RUN edge → all outputs 0, no done, IDLE on the next cycle.
- Back-to-back: hold start=1 for 10 cycles with a=0x0002, b=0x0005, then a=0x00FF, b=0x0001.
  - Required: done pulses 5 cycles apart; sums 0x0007 then 0x0100.
  - Also repeat exhaustively for WIDTH=8 against a + b + cin.

Source files
------------

// File: rtl/cla_nibble_sequencer_if.sv
// Request/result bundle for the nibble-serial adder.
//   master : drives start, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the sequencer side of the same signals
interface cla_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial wide adder: one 4-bit carry-lookahead slice is reused for
// WIDTH/4 clocks, least-significant nibble first, producing a full-width
// sum, carry-out and signed-overflow flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of cla_nibble_sequencer_if
//          start/a/b/cin in (captured on the accepting edge),
//          busy/done/sum/cout/ovf out (all registered)
// WIDTH must be a multiple of 4 and at least 8.
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  bus
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, partial_q, partial_d;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  logic [3:0] slice_in1, slice_in2, slice_sum;
  logic       slice_cout, carry_top;
  logic       accept, last;

  // 4-bit carry-lookahead slice; returns {cout, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] in1,
                                      input logic [3:0] in2,
                                      input logic       cin);
    logic [3:0] g, p;
    logic [4:0] c;
    g = in1 & in2;
    p = in1 ^ in2;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign slice_in1 = a_q[4*k_q +: 4];
  assign slice_in2 = b_q[4*k_q +: 4];
  assign {slice_cout, slice_sum} = cla4(slice_in1, slice_in2, carry_q);

  // Carry into the top bit recovered from the top nibble's bit 3; only
  // meaningful on the last step, which is the only time it is used.
  assign carry_top = slice_in1[3] ^ slice_in2[3] ^ slice_sum[3];

  assign accept = (state_q != RUN) && bus.start;
  assign last   = (state_q == RUN) && (k_q == KLAST);

  // Partial sum with the current nibble merged in, so the final edge can
  // load the complete result straight into sum.
  always_comb begin
    partial_d = partial_q;
    partial_d[4*k_q +: 4] = slice_sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (k_q == KLAST) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
      if (accept) begin
        carry_q <= bus.cin;
        k_q     <= '0;
      end else if (state_q == RUN) begin
        carry_q <= slice_cout;
        if (last) begin
          sum_q  <= partial_d;
          cout_q <= slice_cout;
          ovf_q  <= carry_top ^ slice_cout;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

  // Operand and partial-sum storage carries no reset; it is always
  // reloaded on the accepting edge before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q       <= bus.a;
      b_q       <= bus.b;
      partial_q <= '0;
    end else if (state_q == RUN) begin
      partial_q <= partial_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer: a 16-bit instance for the
// directed vectors and an 8-bit instance swept against a + b + cin.
module tb_cla_nibble_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_nibble_sequencer_if #(.WIDTH(16)) bus16();
  cla_nibble_sequencer_if #(.WIDTH(8))  bus8();

  cla_nibble_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cla_nibble_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Snapshot of {done, busy, ovf, cout, sum} for the 16-bit instance.
  function automatic logic [31:0] st16();
    return 32'({bus16.done, bus16.busy, bus16.ovf, bus16.cout, bus16.sum});
  endfunction

  function automatic logic [31:0] ex16(input logic d, input logic bz, input logic o,
                                       input logic c, input logic [15:0] s);
    return 32'({d, bz, o, c, s});
  endfunction

  // One 16-bit operation started from IDLE, checking the 4-edge latency,
  // that sum holds its old value during RUN, and the single done pulse.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] es, input logic ec, input logic eo);
    logic [15:0] prev;
    logic        pc, po;
    prev = bus16.sum;
    pc   = bus16.cout;
    po   = bus16.ovf;
    bus16.a = a; bus16.b = b; bus16.cin = ci; bus16.start = 1'b1;
    tick;
    bus16.start = 1'b0; bus16.a = ~a; bus16.b = ~b; bus16.cin = ~ci;
    for (int i = 1; i < 4; i++) begin
      check({tag, "_run"}, st16(), ex16(1'b0, 1'b1, po, pc, prev));
      tick;
    end
    check({tag, "_run"}, st16(), ex16(1'b0, 1'b1, po, pc, prev));
    tick;
    check({tag, "_done"}, st16(), ex16(1'b1, 1'b0, eo, ec, es));
    tick;
    check({tag, "_hold"}, st16(), ex16(1'b0, 1'b0, eo, ec, es));
  endtask

  // 8-bit operation accepted in IDLE or DONE; result expected after N=2 edges.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] full;
    logic       eo;
    full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    eo   = (a[7] == b[7]) && (full[7] != a[7]);
    bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0; bus8.a = 8'h5A; bus8.b = 8'hA5; bus8.cin = ~ci;
    tick;
    tick;
    check("w8", 32'({bus8.done, bus8.ovf, bus8.cout, bus8.sum}),
          32'({1'b1, eo, full[8], full[7:0]}));
  endtask

  initial begin
    int ndone, d1, d2;
    logic [15:0] s1, s2;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;

    // Reset held with a pending request.
    rst = 1'b1;
    bus16.start = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.cin = 1'b1;
    tick;
    check("rst_c1", st16(), 32'd0);
    tick;
    check("rst_c2", st16(), 32'd0);
    rst = 1'b0;
    bus16.start = 1'b0;
    tick;
    check("post_rst1", st16(), 32'd0);
    tick;
    check("post_rst2", st16(), 32'd0);

    run16("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16("ripcin",  16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    run16("ovfpos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16("ovfneg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run16("mix1",    16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    run16("mix2",    16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // start pulsed mid-RUN must be ignored.
    bus16.a = 16'h0101; bus16.b = 16'h0202; bus16.cin = 1'b0; bus16.start = 1'b1;
    tick;
    bus16.start = 1'b0;
    tick;
    bus16.start = 1'b1; bus16.a = 16'h1111; bus16.b = 16'h1111;
    tick;
    bus16.start = 1'b0;
    check("busy_ign_run", st16(), ex16(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000));
    tick;
    tick;
    check("busy_ign_done", st16(), ex16(1'b1, 1'b0, 1'b0, 1'b0, 16'h0303));
    tick;
    check("busy_ign_idle", st16(), ex16(1'b0, 1'b0, 1'b0, 1'b0, 16'h0303));

    // Reset at the second RUN edge aborts the operation.
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.start = 1'b1;
    tick;
    bus16.start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    check("abort_rst", st16(), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (bus16.done || bus16.busy) ndone++;
    end
    check("abort_quiet", 32'(ndone), 32'd0);
    check("abort_out", st16(), 32'd0);

    // Back-to-back with start held for 10 cycles.
    bus16.a = 16'h0002; bus16.b = 16'h0005; bus16.cin = 1'b0; bus16.start = 1'b1;
    ndone = 0; d1 = -1; d2 = -1; s1 = '0; s2 = '0;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (i == 0) begin bus16.a = 16'h00FF; bus16.b = 16'h0001; end
      if (i == 9) bus16.start = 1'b0;
      if (bus16.done) begin
        ndone++;
        if (ndone == 1) begin d1 = i; s1 = bus16.sum; end
        else if (ndone == 2) begin d2 = i; s2 = bus16.sum; end
      end
    end
    check("b2b_count", 32'(ndone), 32'd2);
    check("b2b_first", 32'(d1), 32'd4);
    check("b2b_gap",   32'(d2 - d1), 32'd5);
    check("b2b_sum1",  32'(s1), 32'h0007);
    check("b2b_sum2",  32'(s2), 32'h0100);

    // 8-bit sweep including the 0x00/0xFF corners and both carry-ins.
    for (int ai = 0; ai < 256; ai += 5)
      for (int bi = 0; bi < 256; bi += 15)
        for (int ci = 0; ci < 2; ci++)
          op8(8'(ai), 8'(bi), ci[0]);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'h7F, 8'h7F, 1'b1);
    op8(8'h80, 8'hFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
